// File: rtl/ysyx_23060236_clint_pkg.sv
// Shared constants for the CLINT: register offsets, AXI responses, FSM states.
// The CLINT_MTIMECMP_EN build adds mtimecmp, a write channel and timer_irq.
package ysyx_23060236_clint_pkg;

  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;
  localparam logic [15:0] MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI = 16'h4004;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  // Merge the enabled bytes of data into old.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060236_clint_mtime.sv
// Free-running 64-bit mtime counter, advanced once every MTIME_DIV clocks.
module ysyx_23060236_clint_mtime #(
  parameter int MTIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] mtime
);

  localparam int PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;

  logic [PW-1:0] presc;
  logic [63:0]   mtime_q;
  logic          terminal;

  assign terminal = (presc == PW'(MTIME_DIV - 1));
  assign mtime    = mtime_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      mtime_q <= '0;
    end else if (terminal) begin
      presc   <= '0;
      mtime_q <= mtime_q + 64'd1;
    end else begin
      presc   <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060236_clint.sv
// AXI4-Lite CLINT responder serving mtime; with CLINT_MTIMECMP_EN defined it also
// accepts writes to mtimecmp and drives timer_irq.
module ysyx_23060236_clint
  import ysyx_23060236_clint_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0200_0000,
  parameter int          MTIME_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] clint_araddr,
  input  logic        clint_arvalid,
  output logic        clint_arready,
  output logic [31:0] clint_rdata,
  output logic [1:0]  clint_rresp,
  output logic        clint_rvalid,
  input  logic        clint_rready
`ifdef CLINT_MTIMECMP_EN
  ,
  input  logic [31:0] clint_awaddr,
  input  logic        clint_awvalid,
  output logic        clint_awready,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  input  logic        clint_wvalid,
  output logic        clint_wready,
  output logic [1:0]  clint_bresp,
  output logic        clint_bvalid,
  input  logic        clint_bready,
  output logic        timer_irq
`endif
);

  logic [63:0] mtime;

  ysyx_23060236_clint_mtime #(.MTIME_DIV(MTIME_DIV)) u_mtime (
    .clock (clock),
    .reset (reset),
    .mtime (mtime)
  );

`ifdef CLINT_MTIMECMP_EN
  logic [63:0] mtimecmp;
`endif

  // Read decode. The upper offset bits must be zero to hit the window.
  logic [31:0] rd_off;
  logic [31:0] rd_data_next;
  logic [1:0]  rd_resp_next;

  assign rd_off = clint_araddr - ADDR_BASE;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_SLVERR;
    if (rd_off[31:16] == 16'h0) begin
      case (rd_off[15:0])
        MTIME_LO:    begin rd_data_next = mtime[31:0];     rd_resp_next = RESP_OKAY; end
        MTIME_HI:    begin rd_data_next = mtime[63:32];    rd_resp_next = RESP_OKAY; end
`ifdef CLINT_MTIMECMP_EN
        MTIMECMP_LO: begin rd_data_next = mtimecmp[31:0];  rd_resp_next = RESP_OKAY; end
        MTIMECMP_HI: begin rd_data_next = mtimecmp[63:32]; rd_resp_next = RESP_OKAY; end
`endif
        default:     begin rd_data_next = '0;              rd_resp_next = RESP_SLVERR; end
      endcase
    end
  end

  rd_state_e rd_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_state      <= R_IDLE;
      clint_arready <= 1'b1;
      clint_rvalid  <= 1'b0;
      clint_rdata   <= '0;
      clint_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (clint_arvalid && clint_arready) begin
          clint_rdata   <= rd_data_next;
          clint_rresp   <= rd_resp_next;
          clint_arready <= 1'b0;
          clint_rvalid  <= 1'b1;
          rd_state      <= R_RESP;
        end
        R_RESP: if (clint_rready) begin
          clint_rvalid  <= 1'b0;
          clint_arready <= 1'b1;
          rd_state      <= R_IDLE;
        end
      endcase
    end
  end

`ifdef CLINT_MTIMECMP_EN
  // AW and W are captured independently; the write commits when both are held.
  wr_state_e   wr_state;
  logic        aw_got, w_got;
  logic [31:0] aw_off_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs;
  logic [31:0] aw_off_now, aw_off_eff, wdata_eff;
  logic [3:0]  wstrb_eff;

  assign aw_hs      = clint_awvalid && clint_awready;
  assign w_hs       = clint_wvalid && clint_wready;
  assign aw_off_now = clint_awaddr - ADDR_BASE;
  assign aw_off_eff = aw_got ? aw_off_q : aw_off_now;
  assign wdata_eff  = w_got ? wdata_q : clint_wdata;
  assign wstrb_eff  = w_got ? wstrb_q : clint_wstrb;

  // NOTE: mtimecmp resets to all-ones so no interrupt fires before software
  // programs it; the capture registers reset too, keeping the block X-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state      <= W_IDLE;
      clint_awready <= 1'b1;
      clint_wready  <= 1'b1;
      clint_bvalid  <= 1'b0;
      clint_bresp   <= RESP_OKAY;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      aw_off_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      mtimecmp      <= '1;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got        <= 1'b1;
            aw_off_q      <= aw_off_now;
            clint_awready <= 1'b0;
          end
          if (w_hs) begin
            w_got        <= 1'b1;
            wdata_q      <= clint_wdata;
            wstrb_q      <= clint_wstrb;
            clint_wready <= 1'b0;
          end
          if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            clint_awready <= 1'b0;
            clint_wready  <= 1'b0;
            clint_bvalid  <= 1'b1;
            wr_state      <= W_RESP;
            if (aw_off_eff == {16'h0, MTIMECMP_LO}) begin
              mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], wdata_eff, wstrb_eff);
              clint_bresp    <= RESP_OKAY;
            end else if (aw_off_eff == {16'h0, MTIMECMP_HI}) begin
              mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wdata_eff, wstrb_eff);
              clint_bresp     <= RESP_OKAY;
            end else begin
              clint_bresp <= RESP_SLVERR;
            end
          end
        end
        W_RESP: if (clint_bready) begin
          clint_bvalid  <= 1'b0;
          clint_awready <= 1'b1;
          clint_wready  <= 1'b1;
          wr_state      <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timer_irq <= 1'b0;
    else        timer_irq <= (mtime >= mtimecmp);
  end
`endif

endmodule

// File: tb/tb_ysyx_23060236_clint.sv
// Directed bench for ysyx_23060236_clint: dut0 runs MTIME_DIV=1, dut4 MTIME_DIV=4.
// Build with CLINT_MTIMECMP_EN defined to exercise the write channel and timer_irq.
module tb_ysyx_23060236_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] araddr [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

`ifdef CLINT_MTIMECMP_EN
  logic [31:0] awaddr = '0, wdata = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, timer_irq;
  logic [1:0]  bresp;
`endif

  always #5 clock = ~clock;

  // Cycle count since reset release; equals dut0's mtime while MTIME_DIV=1.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  ysyx_23060236_clint #(.ADDR_BASE(BASE), .MTIME_DIV(1)) dut0 (
    .clock(clock), .reset(reset),
    .clint_araddr(araddr[0]), .clint_arvalid(arvalid[0]), .clint_arready(arready[0]),
    .clint_rdata(rdata[0]), .clint_rresp(rresp[0]), .clint_rvalid(rvalid[0]),
    .clint_rready(rready[0])
`ifdef CLINT_MTIMECMP_EN
    , .clint_awaddr(awaddr), .clint_awvalid(awvalid), .clint_awready(awready),
    .clint_wdata(wdata), .clint_wstrb(wstrb), .clint_wvalid(wvalid), .clint_wready(wready),
    .clint_bresp(bresp), .clint_bvalid(bvalid), .clint_bready(bready), .timer_irq(timer_irq)
`endif
  );

`ifdef CLINT_MTIMECMP_EN
  logic       awready4, wready4, bvalid4, timer_irq4;
  logic [1:0] bresp4;
`endif

  ysyx_23060236_clint #(.ADDR_BASE(BASE), .MTIME_DIV(4)) dut4 (
    .clock(clock), .reset(reset),
    .clint_araddr(araddr[1]), .clint_arvalid(arvalid[1]), .clint_arready(arready[1]),
    .clint_rdata(rdata[1]), .clint_rresp(rresp[1]), .clint_rvalid(rvalid[1]),
    .clint_rready(rready[1])
`ifdef CLINT_MTIMECMP_EN
    , .clint_awaddr(32'h0), .clint_awvalid(1'b0), .clint_awready(awready4),
    .clint_wdata(32'h0), .clint_wstrb(4'h0), .clint_wvalid(1'b0), .clint_wready(wready4),
    .clint_bresp(bresp4), .clint_bvalid(bvalid4), .clint_bready(1'b1), .timer_irq(timer_irq4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; AR handshake on the next posedge, response accepted one
  // cycle later (plus hold cycles with rready low). Returns at a negedge.
  task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    check("arready_idle", arready[d], 1'b1);
    araddr[d]  = addr;
    arvalid[d] = 1'b1;
    rready[d]  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    arvalid[d] = 1'b0;
    check("rvalid_latency", rvalid[d], 1'b1);
    data = rdata[d];
    resp = rresp[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("hold_rvalid", rvalid[d], 1'b1);
      check("hold_rdata", rdata[d], data);
      check("hold_arready", arready[d], 1'b0);
    end
    rready[d] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rready[d] = 1'b0;
    check("rvalid_drop", rvalid[d], 1'b0);
    check("arready_back", arready[d], 1'b1);
  endtask

`ifdef CLINT_MTIMECMP_EN
  task automatic do_write(input bit w_first, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    wdata = data; wstrb = strb; awaddr = addr;
    wvalid = 1'b1;
    if (!w_first) awvalid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wvalid = 1'b0;
    if (w_first) begin
      check("w_first_wready", wready, 1'b0);
      check("w_first_awready", awready, 1'b1);
      check("w_first_no_b", bvalid, 1'b0);
      awvalid = 1'b1;
      @(posedge clock);
      @(negedge clock);
    end
    awvalid = 1'b0;
    check("bvalid", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    bready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bready = 1'b0;
    check("bvalid_drop", bvalid, 1'b0);
    check("awready_back", awready, 1'b1);
  endtask
`endif

  initial begin
    logic [31:0] d, d1;
    logic [1:0]  r;
    int          exp_t;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
    end

    // 1. Reset state, then mtime after 10 idle cycles.
    repeat (3) @(negedge clock);
    check("rst_arready", arready[0], 1'b1);
    check("rst_rvalid", rvalid[0], 1'b0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_rresp", rresp[0], 2'b00);
`ifdef CLINT_MTIMECMP_EN
    check("rst_irq", timer_irq, 1'b0);
`endif
    reset = 1'b1;
    repeat (10) @(negedge clock);
    do_read(0, BASE + 32'hBFF8, 0, d, r);
    check("mtime_after_10", d, 32'd10);
    check("mtime_rresp", r, 2'b00);

    // 2. Backpressure: rready low for 5 cycles.
    exp_t = cyc;
    do_read(0, BASE + 32'hBFF8, 5, d, r);
    check("mtime_held", d, exp_t);

    // 4. MTIME_DIV=4: 40 cycles between handshakes advance mtime by 10.
    do_read(1, BASE + 32'hBFF8, 0, d1, r);
    repeat (38) @(negedge clock);
    do_read(1, BASE + 32'hBFF8, 0, d, r);
    check("div4_delta", d - d1, 32'd10);
    do_read(1, BASE + 32'h0000, 0, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", r, 2'b10);

    // 3. Carry from low to high word: read hi, then lo, each right after a tick.
    for (int k = 0; k < 2; k++) begin
      force dut0.u_mtime.mtime_q = 64'h0000_0000_FFFF_FFFF;
      @(posedge clock);
      @(negedge clock);
      release dut0.u_mtime.mtime_q;
      @(negedge clock);
      do_read(0, BASE + ((k == 0) ? 32'hBFFC : 32'hBFF8), 0, d, r);
      check((k == 0) ? "carry_hi" : "carry_lo", d, (k == 0) ? 32'h1 : 32'h0);
    end

    // 6. Reset while a response is pending.
    araddr[0] = BASE + 32'hBFF8; arvalid[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    arvalid[0] = 1'b0;
    check("pre_rst_rvalid", rvalid[0], 1'b1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid[0], 1'b0);
    check("mid_rst_arready", arready[0], 1'b1);
    check("mid_rst_rdata", rdata[0], 32'h0);
    @(negedge clock);
    reset = 1'b1;
    do_read(0, BASE + 32'hBFF8, 0, d, r);
    check("mtime_after_rst", d, 32'h0);

`ifdef CLINT_MTIMECMP_EN
    // 5. mtimecmp writes and the timer interrupt.
    do_read(0, BASE + 32'h4000, 0, d, r);
    check("cmp_rst_lo", d, 32'hFFFF_FFFF);
    check("cmp_rst_resp", r, 2'b00);
    do_write(1'b1, BASE + 32'h4000, 32'h20, 4'hF, 2'b00);
    do_write(1'b0, BASE + 32'h4004, 32'h0, 4'hF, 2'b00);
    do_read(0, BASE + 32'h4000, 0, d, r);
    check("cmp_lo_readback", d, 32'h20);
    do_write(1'b0, BASE + 32'hBFF8, 32'h0, 4'hF, 2'b10);
    exp_t = cyc;
    do_read(0, BASE + 32'hBFF8, 0, d, r);
    check("mtime_not_written", d, exp_t);
    for (int i = 0; i < 100 && cyc < 32; i++) @(negedge clock);
    check("cyc_reached_32", cyc, 32);
    check("irq_before", timer_irq, 1'b0);
    @(negedge clock);
    check("irq_after", timer_irq, 1'b1);
`else
    do_read(0, BASE + 32'h4000, 0, d, r);
    check("cmp_absent_rdata", d, 32'h0);
    check("cmp_absent_rresp", r, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
